// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch front end: polarity levels,
// bus widths and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

endpackage

// File: rtl/if_fetch_if.sv
// Request/acknowledge instruction bus between the fetch unit (master) and
// the instruction memory (slave).
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   ibus_req_o;
    logic [InstAddrBus-1:0] ibus_addr_o;
    logic                   ibus_ack_i;
    logic [InstBus-1:0]     ibus_rdata_i;

    modport master (output ibus_req_o, output ibus_addr_o,
                    input  ibus_ack_i, input  ibus_rdata_i);
    modport slave  (input  ibus_req_o, input  ibus_addr_o,
                    output ibus_ack_i, output ibus_rdata_i);

endinterface

// File: rtl/if_fetch_buf.sv
// Side storage for the fetch unit: the stalled instruction word, the latched
// branch redirect, and the address still owed an ack after a flush.
module if_fetch_buf
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   buf_load_i,
    input  logic                   buf_clr_i,
    input  logic [InstBus-1:0]     buf_data_i,
    input  logic                   br_set_i,
    input  logic                   br_clr_i,
    input  logic [InstAddrBus-1:0] br_target_i,
    input  logic                   old_load_i,
    input  logic [InstAddrBus-1:0] old_addr_i,
    output logic                   buf_valid_o,
    output logic [InstBus-1:0]     buf_o,
    output logic                   br_pend_o,
    output logic [InstAddrBus-1:0] br_tgt_o,
    output logic [InstAddrBus-1:0] old_addr_o
);

    logic                   buf_valid_q, buf_valid_d;
    logic [InstBus-1:0]     buf_q, buf_d;
    logic                   br_pend_q, br_pend_d;
    logic [InstAddrBus-1:0] br_tgt_q, br_tgt_d;
    logic [InstAddrBus-1:0] old_addr_q, old_addr_d;

    // A set and a clear never arrive together: the top only sets the branch
    // latch when the instruction is neither advancing nor being flushed.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        br_pend_d   = br_pend_q;
        br_tgt_d    = br_tgt_q;
        old_addr_d  = old_addr_q;
        if (buf_load_i) begin
            buf_valid_d = 1'b1;
            buf_d       = buf_data_i;
        end else if (buf_clr_i) begin
            buf_valid_d = 1'b0;
        end
        if (br_clr_i) begin
            br_pend_d = 1'b0;
        end else if (br_set_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_target_i;
        end
        if (old_load_i) begin
            old_addr_d = old_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            buf_valid_q <= 1'b0;
            buf_q       <= ZeroWord;
            br_pend_q   <= 1'b0;
            br_tgt_q    <= '0;
            old_addr_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            br_pend_q   <= br_pend_d;
            br_tgt_q    <= br_tgt_d;
            old_addr_q  <= old_addr_d;
        end
    end

    assign buf_valid_o = buf_valid_q;
    assign buf_o       = buf_q;
    assign br_pend_o   = br_pend_q;
    assign br_tgt_o    = br_tgt_q;
    assign old_addr_o  = old_addr_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC and fetch FSM, masters the ibus.
// Define IF_PERF_CNT_EN to add the fetch_wait_cnt_o stall-cycle counter.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    if_fetch_if.master             ibus,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   stallreq_if_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_wait_cnt_o
`endif
);

    logic [1:0]             state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] next_pc;
    logic                   req, ack_v, stop, advance;
    logic                   buf_valid, br_pend;
    logic [InstBus-1:0]     buf_word;
    logic [InstAddrBus-1:0] br_tgt, old_addr;
    logic                   unused_stall;

    assign unused_stall = ^stall[5:1];
    assign stop    = (stall[0] == Stop);
    assign req     = (rst != RstEnable) && (state_q == S_FETCH || state_q == S_DISCARD);
    assign ack_v   = ibus.ibus_ack_i & req;
    assign advance = !flush && ((state_q == S_FETCH && ack_v && !stop) ||
                                (state_q == S_HOLD && !stop));
    assign next_pc = br_pend       ? br_tgt :
                     branch_flag_i ? branch_target_i : pc_q + 32'd4;

    if_fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .buf_load_i  (!flush && state_q == S_FETCH && ack_v && stop),
        .buf_clr_i   (flush || (state_q == S_HOLD && !stop)),
        .buf_data_i  (ibus.ibus_rdata_i),
        .br_set_i    (branch_flag_i && !flush && !advance),
        .br_clr_i    (flush || advance),
        .br_target_i (branch_target_i),
        .old_load_i  (flush && state_q == S_FETCH && !ack_v),
        .old_addr_i  (pc_q),
        .buf_valid_o (buf_valid),
        .buf_o       (buf_word),
        .br_pend_o   (br_pend),
        .br_tgt_o    (br_tgt),
        .old_addr_o  (old_addr)
    );

    // A flush redirects the PC at once, but a request already on the bus
    // cannot be withdrawn, so its ack is absorbed in DISCARD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (flush) begin
            pc_d = new_pc;
            case (state_q)
                S_FETCH, S_DISCARD: state_d = ack_v ? S_FETCH : S_DISCARD;
                default:            state_d = S_FETCH;
            endcase
        end else begin
            if (advance) pc_d = next_pc;
            case (state_q)
                S_BOOT:    state_d = S_FETCH;
                S_FETCH:   if (ack_v && stop) state_d = S_HOLD;
                S_HOLD:    if (!stop) state_d = S_FETCH;
                S_DISCARD: if (ack_v) state_d = S_FETCH;
                default:   state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        ibus.ibus_addr_o = '0;
        if_pc            = '0;
        if_inst          = ZeroWord;
        stallreq_if_o    = 1'b0;
        if (rst != RstEnable) begin
            case (state_q)
                S_FETCH: begin
                    ibus.ibus_addr_o = pc_q;
                    if_pc            = pc_q;
                    if_inst          = (ack_v && !flush) ? ibus.ibus_rdata_i : ZeroWord;
                    stallreq_if_o    = !ibus.ibus_ack_i;
                end
                S_HOLD: begin
                    ibus.ibus_addr_o = pc_q;
                    if_pc            = pc_q;
                    if_inst          = buf_valid ? buf_word : ZeroWord;
                end
                S_DISCARD: begin
                    ibus.ibus_addr_o = old_addr;
                    if_pc            = pc_q;
                    stallreq_if_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ibus.ibus_req_o = req;

`ifdef IF_PERF_CNT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (stallreq_if_o && wait_cnt_q != 32'hFFFF_FFFF) wait_cnt_d = wait_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) wait_cnt_q <= '0;
        else                  wait_cnt_q <= wait_cnt_d;
    end

    assign fetch_wait_cnt_o = wait_cnt_q;
`endif

endmodule
